// File: rtl/memoria_pkg.sv
// Shared definitions for the memory blocks: FSM state encoding and the
// address-width derivation every memory block uses for its address ports.
package memoria_pkg;

  typedef enum logic {
    ST_LIMPANDO = 1'b0,
    ST_PRONTO   = 1'b1
  } estado_t;

  // A one-word-deep memory would give $clog2 = 0; keep at least one address bit.
  function automatic int addr_w(input int profundidade);
    return (profundidade > 1) ? $clog2(profundidade) : 1;
  endfunction

endpackage

// File: rtl/memoria_ram_nxm_if.sv
// Request/response bundle of the RAM. A request (ler and/or escrever) is sampled
// on every posedge; it is accepted only when ocupado is low and endereco is in
// range, otherwise erro pulses on the following cycle.
interface memoria_ram_nxm_if #(
  parameter  int LARGURA      = 8,
  parameter  int PROFUNDIDADE = 16,
  localparam int ADDR_W       = memoria_pkg::addr_w(PROFUNDIDADE)
);

  logic              escrever;
  logic              ler;
  logic [ADDR_W-1:0] endereco;
  logic [LARGURA-1:0] dado_in;
  logic [LARGURA-1:0] dado_out;
  logic              dado_valido;
  logic              ocupado;
  logic              erro;

  modport master (
    output escrever, ler, endereco, dado_in,
    input  dado_out, dado_valido, ocupado, erro
  );

  modport slave (
    input  escrever, ler, endereco, dado_in,
    output dado_out, dado_valido, ocupado, erro
  );

endinterface

// File: rtl/memoria_ram_nxm_contador_limpeza.sv
// Address counter for the post-reset clear sweep; terminal flags the last word.
module contador_limpeza #(
  parameter int PROFUNDIDADE = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              limpar,
  input  logic              habilitar,
  output logic [ADDR_W-1:0] contador,
  output logic              terminal
);

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(PROFUNDIDADE - 1);

  always_ff @(posedge clk) begin
    if (limpar) begin
      contador <= '0;
    end else if (habilitar) begin
      contador <= contador + ADDR_W'(1);
    end
  end

  assign terminal = (contador == ULTIMO);

endmodule

// File: rtl/memoria_ram_nxm.sv
// Single-port LARGURA x PROFUNDIDADE RAM with registered read, write-first
// collisions, a post-reset clear sweep and rejection of illegal requests.
module memoria_ram_nxm
  import memoria_pkg::*;
#(
  parameter  int LARGURA      = 8,
  parameter  int PROFUNDIDADE = 16,
  localparam int ADDR_W       = addr_w(PROFUNDIDADE)
) (
  input  logic                    clk,
  input  logic                    reset,
  memoria_ram_nxm_if.slave        bus,
  output estado_t                 estado
);

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(PROFUNDIDADE - 1);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];

  estado_t            estado_next;
  logic [ADDR_W-1:0]  contador;
  logic               terminal;
  logic               cnt_en;
  logic               pedido;
  logic               end_ok;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [LARGURA-1:0] mem_wdata;
  logic               ler_ok;
  logic               erro_next;

  contador_limpeza #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .ADDR_W       (ADDR_W)
  ) u_contador (
    .clk       (clk),
    .limpar    (reset),
    .habilitar (cnt_en),
    .contador  (contador),
    .terminal  (terminal)
  );

  assign pedido = bus.ler | bus.escrever;
  assign end_ok = (bus.endereco <= ULTIMO);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= ST_LIMPANDO;
    end else begin
      estado <= estado_next;
    end
  end

  // While clearing, the memory port belongs to the sweep and requests are refused.
  always_comb begin
    estado_next = estado;
    cnt_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = bus.endereco;
    mem_wdata   = bus.dado_in;
    ler_ok      = 1'b0;
    erro_next   = 1'b0;
    case (estado)
      ST_LIMPANDO: begin
        cnt_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = contador;
        mem_wdata = '0;
        erro_next = pedido;
        if (terminal) begin
          estado_next = ST_PRONTO;
        end
      end
      ST_PRONTO: begin
        if (pedido) begin
          if (!end_ok) begin
            erro_next = 1'b1;
          end else begin
            mem_we = bus.escrever;
            ler_ok = bus.ler;
          end
        end
      end
      default: estado_next = ST_LIMPANDO;
    endcase
  end

  // No reset on the array so it maps onto RAM; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dado_out    <= '0;
      bus.dado_valido <= 1'b0;
      bus.erro        <= 1'b0;
    end else begin
      bus.dado_valido <= ler_ok;
      bus.erro        <= erro_next;
      if (ler_ok) begin
        bus.dado_out <= bus.escrever ? bus.dado_in : mem[bus.endereco];
      end
    end
  end

  assign bus.ocupado = (estado == ST_LIMPANDO);

endmodule

// File: tb/tb_memoria_ram_nxm.sv
// Bench for memoria_ram_nxm: a 16-word and a 12-word instance driven side by
// side and compared every cycle against a word-level reference model.
module tb_memoria_ram_nxm;
  import memoria_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       we_v [2];
  logic       re_v [2];
  logic [3:0] a_v  [2];
  logic [7:0] d_v  [2];
  estado_t    est16, est12;

  memoria_ram_nxm_if #(.LARGURA(8), .PROFUNDIDADE(16)) bus16 ();
  memoria_ram_nxm_if #(.LARGURA(8), .PROFUNDIDADE(12)) bus12 ();

  assign bus16.escrever = we_v[0];
  assign bus16.ler      = re_v[0];
  assign bus16.endereco = a_v[0];
  assign bus16.dado_in  = d_v[0];
  assign bus12.escrever = we_v[1];
  assign bus12.ler      = re_v[1];
  assign bus12.endereco = a_v[1];
  assign bus12.dado_in  = d_v[1];

  memoria_ram_nxm #(.LARGURA(8), .PROFUNDIDADE(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave), .estado(est16));
  memoria_ram_nxm #(.LARGURA(8), .PROFUNDIDADE(12)) dut12 (
    .clk(clk), .reset(reset), .bus(bus12.slave), .estado(est12));

  // ---------------- reference model ----------------
  logic [7:0] mdl_mem  [2][16];
  logic [7:0] mdl_dout [2];
  logic       mdl_val  [2];
  logic       mdl_err  [2];
  int         mdl_clr  [2];
  logic [7:0] exp_q[$];

  int n_asrt = 0;
  int n_fail = 0;

  function automatic int dep(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  task automatic model_edge(input int i);
    if (reset) begin
      mdl_clr[i]  = dep(i);
      mdl_dout[i] = 8'h00;
      mdl_val[i]  = 1'b0;
      mdl_err[i]  = 1'b0;
      for (int k = 0; k < 16; k++) mdl_mem[i][k] = 8'h00;
    end else begin
      mdl_val[i] = 1'b0;
      mdl_err[i] = 1'b0;
      if (mdl_clr[i] > 0) begin
        mdl_err[i] = we_v[i] | re_v[i];
        mdl_clr[i]--;
      end else if ((we_v[i] | re_v[i]) && int'(a_v[i]) >= dep(i)) begin
        mdl_err[i] = 1'b1;
      end else begin
        if (we_v[i]) mdl_mem[i][a_v[i]] = d_v[i];
        if (re_v[i]) begin
          mdl_dout[i] = mdl_mem[i][a_v[i]];
          mdl_val[i]  = 1'b1;
          if (i == 0) exp_q.push_back(mdl_mem[i][a_v[i]]);
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input int i, input logic [7:0] dout, input logic val,
                       input logic err, input logic ocp, input estado_t est);
    logic [7:0] want;
    n_asrt++;
    assert (dout === mdl_dout[i]) else begin
      n_fail++; $error("FAIL dado_out[%0d] got %h expected %h", i, dout, mdl_dout[i]);
    end
    n_asrt++;
    assert (val === mdl_val[i]) else begin
      n_fail++; $error("FAIL dado_valido[%0d] got %b expected %b", i, val, mdl_val[i]);
    end
    n_asrt++;
    assert (err === mdl_err[i]) else begin
      n_fail++; $error("FAIL erro[%0d] got %b expected %b", i, err, mdl_err[i]);
    end
    n_asrt++;
    assert (ocp === (mdl_clr[i] > 0)) else begin
      n_fail++; $error("FAIL ocupado[%0d] got %b expected %b", i, ocp, mdl_clr[i] > 0);
    end
    n_asrt++;
    assert (est === ((mdl_clr[i] > 0) ? ST_LIMPANDO : ST_PRONTO)) else begin
      n_fail++; $error("FAIL estado[%0d] got %b expected busy=%b", i, est, mdl_clr[i] > 0);
    end
    if (i == 0 && mdl_val[i] && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_asrt++;
      assert (dout === want) else begin
        n_fail++; $error("FAIL read_data got %h expected %h", dout, want);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge(0);
    model_edge(1);
    check(0, bus16.dado_out, bus16.dado_valido, bus16.erro, bus16.ocupado, est16);
    check(1, bus12.dado_out, bus12.dado_valido, bus12.erro, bus12.ocupado, est12);
  endtask

  task automatic drive(input int i, input logic we, input logic re,
                       input int a, input int d);
    we_v[i] = we;
    re_v[i] = re;
    a_v[i]  = 4'(a);
    d_v[i]  = 8'(d);
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic read_all();
    for (int k = 0; k < 16; k++) begin
      drive(0, 1'b0, 1'b1, k, 0);
      drive(1, 1'b0, 1'b1, k, 0);
      tick();
    end
    idle_all();
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    idle_all();
    for (int i = 0; i < 2; i++) mdl_clr[i] = 0;
    tick();
    tick();
    reset = 1'b0;

    // write request on the first clear cycle must be refused
    drive(0, 1'b1, 1'b0, 0, 8'hFF);
    drive(1, 1'b1, 1'b0, 0, 8'hFF);
    tick();
    idle_all();
    for (int k = 1; k < 16; k++) tick();
    tick();
    read_all();

    // write then back-to-back reads
    drive(0, 1'b1, 1'b0, 3, 8'hAA);  tick();
    drive(0, 1'b1, 1'b0, 15, 8'h55); tick();
    drive(0, 1'b0, 1'b1, 3, 0);      tick();
    drive(0, 1'b0, 1'b1, 15, 0);     tick();
    idle_all(); tick(); tick();

    // write-first collision
    drive(0, 1'b1, 1'b0, 7, 8'h11);  tick();
    drive(0, 1'b1, 1'b1, 7, 8'h3C);  tick();
    idle_all();                      tick();
    drive(0, 1'b0, 1'b1, 7, 0);      tick();
    idle_all();                      tick();

    // out-of-range on the 12-word instance
    drive(1, 1'b1, 1'b0, 5, 8'h77);  tick();
    drive(1, 1'b0, 1'b1, 5, 0);      tick();
    drive(1, 1'b0, 1'b1, 13, 0);     tick();
    drive(1, 1'b1, 1'b0, 13, 8'hEE); tick();
    drive(1, 1'b1, 1'b1, 13, 8'hEE); tick();
    idle_all(); tick();
    read_all();

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 2; i++)
        drive(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15), $urandom_range(0, 255));
      tick();
    end
    reset = 1'b0;
    idle_all();
    for (int k = 0; k < 17; k++) tick();

    // reset in the middle of the clear sweep restarts it
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
